pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage core. It decides each cycle whether the F/D and D/E pipeline registers advance, hold (`lock`), take a bubble, or are flushed. It resolves data hazards with Tuse/Tnew comparison and owns the multiply/divide busy countdown. It also sequences exception and `eret` redirection. It sits beside the D stage and drives the `lock`/`res`-clear inputs of every inter-stage register.

---
 rtl/pipe_hazard_ctrl.sv | 67 ++++++
 tb/tb_pipe_hazard_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/redirect sequencing for the five-stage core
// Ports: clk, reset (async active-low); D sources d_rs/d_rt with d_tuse_*;
//   E/M producers e_dst/m_dst with e_tnew/m_tnew; mult/div d_is_md, md_start,
//   md_is_div; redirects exc_req, eret_m. Outputs lock_f, lock_d, clr_e, flush,
//   pc_sel (00 seq, 01 handler, 10 EPC), md_busy, stall_cnt (saturating).
// Build option: define PIPE_CTRL_MDU_EN to include the mult/div busy counter.
module pipe_hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic [1:0]       d_tuse_rs,
  input  logic [1:0]       d_tuse_rt,
  input  logic [4:0]       e_dst,
  input  logic [4:0]       m_dst,
  input  logic [1:0]       e_tnew,
  input  logic [1:0]       m_tnew,
  input  logic             d_is_md,
  input  logic             md_start,
  input  logic             md_is_div,
  input  logic             exc_req,
  input  logic             eret_m,
  output logic             lock_f,
  output logic             lock_d,
  output logic             clr_e,
  output logic             flush,
  output logic [1:0]       pc_sel,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);
  logic stall_data, stall_md, stall;
  assign stall_data = (d_rs != 5'd0 && d_rs == e_dst && d_tuse_rs < e_tnew) ||
                      (d_rs != 5'd0 && d_rs == m_dst && d_tuse_rs < m_tnew) ||
                      (d_rt != 5'd0 && d_rt == e_dst && d_tuse_rt < e_tnew) ||
                      (d_rt != 5'd0 && d_rt == m_dst && d_tuse_rt < m_tnew);
`ifdef PIPE_CTRL_MDU_EN
  localparam int MW = $clog2(DIV_CYC + 1);
  logic [MW-1:0] md_cnt;
  // exc_req flushes the E-stage mult/div, so it must not start the countdown
  always_ff @(posedge clk or negedge reset)
    if (!reset) md_cnt <= '0;
    else if (md_start && !exc_req) md_cnt <= md_is_div ? MW'(DIV_CYC) : MW'(MULT_CYC);
    else if (md_cnt != '0) md_cnt <= md_cnt - 1'b1;
  assign md_busy = md_cnt != '0;
  assign stall_md = d_is_md && (md_busy || md_start);
`else
  logic unused_mdu;
  assign unused_mdu = ^{d_is_md, md_start, md_is_div, MULT_CYC[0], DIV_CYC[0]};
  assign md_busy = 1'b0;
  assign stall_md = 1'b0;
`endif
  assign stall = stall_data || stall_md;
  always_comb begin
    flush = reset && (exc_req || eret_m);
    pc_sel = !reset ? 2'b00 : exc_req ? 2'b01 : eret_m ? 2'b10 : 2'b00;
    lock_f = reset && stall && !exc_req && !eret_m;
    lock_d = lock_f;
    clr_e = lock_f;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) stall_cnt <= '0;
    else if (lock_f && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and randomized checks of pipe_hazard_ctrl against a reference model
module tb_pipe_hazard_ctrl;
  localparam int MULT = 5;
  localparam int DIV = 10;
  localparam int CW = 5;
  localparam int SAT = (1 << CW) - 1;
`ifdef PIPE_CTRL_MDU_EN
  localparam bit MDU = 1'b1;
`else
  localparam bit MDU = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] d_rs, d_rt, e_dst, m_dst;
  logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
  logic d_is_md, md_start, md_is_div, exc_req, eret_m;
  logic lock_f, lock_d, clr_e, flush, md_busy;
  logic [1:0] pc_sel;
  logic [CW-1:0] stall_cnt;
  logic [6:0] outs;
  int n_checks = 0;
  int n_fail = 0;
  int md_rem = 0;
  int scnt = 0;

  pipe_hazard_ctrl #(.MULT_CYC(MULT), .DIV_CYC(DIV), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .e_dst(e_dst), .m_dst(m_dst),
    .e_tnew(e_tnew), .m_tnew(m_tnew), .d_is_md(d_is_md), .md_start(md_start),
    .md_is_div(md_is_div), .exc_req(exc_req), .eret_m(eret_m), .lock_f(lock_f),
    .lock_d(lock_d), .clr_e(clr_e), .flush(flush), .pc_sel(pc_sel),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;
  assign outs = {lock_f, lock_d, clr_e, flush, pc_sel, md_busy};

  // a mult/div cannot reach E while the unit is busy: it is held in D
  always @(posedge clk)
    if (reset && md_start) assert (!md_busy) else $error("md_start while busy");

  // Expected {lock_f, lock_d, clr_e, flush, pc_sel, md_busy} from the hazard rules
  function automatic logic [6:0] model_comb();
    logic [4:0] src [2];
    logic [4:0] dst [2];
    int tuse [2];
    int tnew [2];
    bit hz, busy, st;
    src = '{d_rs, d_rt};
    dst = '{e_dst, m_dst};
    tuse = '{int'(d_tuse_rs), int'(d_tuse_rt)};
    tnew = '{int'(e_tnew), int'(m_tnew)};
    hz = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        if (src[i] != 0 && src[i] == dst[j] && tuse[i] < tnew[j]) hz = 1'b1;
    busy = md_rem > 0;
    st = hz || (MDU && d_is_md && (busy || md_start));
    if (!reset) return 7'b0;
    if (exc_req) return {3'b000, 1'b1, 2'b01, busy};
    if (eret_m) return {3'b000, 1'b1, 2'b10, busy};
    return {st, st, st, 1'b0, 2'b00, busy};
  endfunction

  task automatic tick();
    logic [6:0] e;
    bit start, dv, exc;
    e = model_comb();
    start = md_start;
    dv = md_is_div;
    exc = exc_req;
    @(posedge clk);
    if (reset) begin
      if (e[6] && scnt < SAT) scnt++;
      if (MDU) begin
        if (start && !exc) md_rem = dv ? DIV : MULT;
        else if (md_rem > 0) md_rem--;
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    d_rs = 0; d_rt = 0; e_dst = 0; m_dst = 0;
    d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; e_tnew = 0; m_tnew = 0;
    d_is_md = 0; md_start = 0; md_is_div = 0; exc_req = 0; eret_m = 0;
  endtask

  task automatic lw_hazard();
    e_dst = 5'd8; e_tnew = 2'd2; d_rs = 5'd8; d_tuse_rs = 2'd1;
  endtask

  task automatic test_reset();
    clear_inputs();
    lw_hazard();
    exc_req = 1;
    #1;
    n_checks++;
    if (outs !== 7'b0) begin n_fail++; $display("FAIL reset_outs: got %b expected %b", outs, 7'b0); end
    n_checks++;
    if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", stall_cnt); end
    @(posedge clk);
    @(posedge clk);
    #1;
    clear_inputs();
    reset = 1;
    tick();
    n_checks++;
    if (outs !== 7'b0 || stall_cnt !== '0) begin
      n_fail++; $display("FAIL reset_release: got %b/%0d expected 0/0", outs, stall_cnt);
    end
  endtask

  task automatic test_lw_use();
    clear_inputs();
    lw_hazard();
    #1;
    n_checks++;
    if (outs !== 7'b1110000) begin n_fail++; $display("FAIL lw_use: got %b expected %b", outs, 7'b1110000); end
    tick();
    n_checks++;
    if (stall_cnt !== 5'd1) begin n_fail++; $display("FAIL lw_use_cnt: got %0d expected 1", stall_cnt); end
  endtask

  task automatic test_zero_filter();
    clear_inputs();
    e_tnew = 2'd2;
    d_tuse_rs = 2'd0;
    #1;
    n_checks++;
    if (outs !== 7'b0) begin n_fail++; $display("FAIL zero_filter: got %b expected %b", outs, 7'b0); end
    tick();
    n_checks++;
    if (stall_cnt !== 5'd1) begin n_fail++; $display("FAIL zero_cnt: got %0d expected 1", stall_cnt); end
  endtask

  task automatic test_div_busy();
    int c0;
    c0 = scnt;
    clear_inputs();
    md_start = 1; md_is_div = 1; d_is_md = 1;
    #1;
    n_checks++;
    if (outs !== {{3{MDU}}, 4'b0000}) begin n_fail++; $display("FAIL div_start: got %b expected %b", outs, {{3{MDU}}, 4'b0000}); end
    tick();
    md_start = 0;
    md_is_div = 0;
    for (int i = 0; i < DIV; i++) begin
      #1;
      n_checks++;
      if (outs !== {{3{MDU}}, 3'b000, MDU}) begin
        n_fail++; $display("FAIL div_busy[%0d]: got %b expected %b", i, outs, {{3{MDU}}, 3'b000, MDU});
      end
      tick();
    end
    #1;
    n_checks++;
    if (outs !== 7'b0) begin n_fail++; $display("FAIL div_release: got %b expected %b", outs, 7'b0); end
    n_checks++;
    if (int'(stall_cnt) !== c0 + (MDU ? DIV + 1 : 0)) begin
      n_fail++; $display("FAIL div_cnt: got %0d expected %0d", stall_cnt, c0 + (MDU ? DIV + 1 : 0));
    end
  endtask

  task automatic test_exception();
    int c0;
    c0 = scnt;
    clear_inputs();
    lw_hazard();
    exc_req = 1; md_start = 1; d_is_md = 1;
    #1;
    n_checks++;
    if (outs !== 7'b0001010) begin n_fail++; $display("FAIL exc_stall: got %b expected %b", outs, 7'b0001010); end
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (md_busy !== 1'b0) begin n_fail++; $display("FAIL exc_no_load: got %b expected 0", md_busy); end
    n_checks++;
    if (int'(stall_cnt) !== c0) begin n_fail++; $display("FAIL exc_cnt: got %0d expected %0d", stall_cnt, c0); end
  endtask

  task automatic test_eret();
    int c0;
    c0 = scnt;
    clear_inputs();
    lw_hazard();
    eret_m = 1;
    #1;
    n_checks++;
    if (outs !== 7'b0001100) begin n_fail++; $display("FAIL eret: got %b expected %b", outs, 7'b0001100); end
    exc_req = 1;
    #1;
    n_checks++;
    if (outs !== 7'b0001010) begin n_fail++; $display("FAIL eret_exc: got %b expected %b", outs, 7'b0001010); end
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (int'(stall_cnt) !== c0) begin n_fail++; $display("FAIL eret_cnt: got %0d expected %0d", stall_cnt, c0); end
  endtask

  task automatic test_async_reset();
    clear_inputs();
    md_start = 1;
    tick();
    md_start = 0;
    tick();
    tick();
    n_checks++;
    if (md_busy !== MDU) begin n_fail++; $display("FAIL mult_busy: got %b expected %b", md_busy, MDU); end
    lw_hazard();
    exc_req = 1;
    #2;
    reset = 0;
    md_rem = 0;
    scnt = 0;
    #1;
    n_checks++;
    if (md_busy !== 1'b0 || stall_cnt !== '0) begin
      n_fail++; $display("FAIL async_reset: got busy %b cnt %0d expected 0/0", md_busy, stall_cnt);
    end
    n_checks++;
    if (outs !== 7'b0) begin n_fail++; $display("FAIL async_outs: got %b expected %b", outs, 7'b0); end
    #2;
    reset = 1;
    clear_inputs();
    d_is_md = 1;
    #1;
    n_checks++;
    if (outs !== 7'b0) begin n_fail++; $display("FAIL stale_busy: got %b expected %b", outs, 7'b0); end
    tick();
    n_checks++;
    if (outs !== 7'b0 || stall_cnt !== '0) begin
      n_fail++; $display("FAIL post_reset: got %b/%0d expected 0/0", outs, stall_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      d_rs = 5'($urandom_range(0, 3));
      d_rt = 5'($urandom_range(0, 3));
      e_dst = 5'($urandom_range(0, 3));
      m_dst = 5'($urandom_range(0, 3));
      d_tuse_rs = 2'($urandom);
      d_tuse_rt = 2'($urandom);
      e_tnew = 2'($urandom);
      m_tnew = 2'($urandom);
      d_is_md = 1'($urandom_range(0, 2) == 0);
      md_is_div = 1'($urandom);
      md_start = (md_rem == 0) && ($urandom_range(0, 5) == 0);
      exc_req = $urandom_range(0, 7) == 0;
      eret_m = $urandom_range(0, 7) == 0;
      #1;
      n_checks++;
      if (outs !== model_comb()) begin n_fail++; $display("FAIL rand_outs[%0d]: got %b expected %b", i, outs, model_comb()); end
      n_checks++;
      if (int'(stall_cnt) !== scnt) begin n_fail++; $display("FAIL rand_cnt[%0d]: got %0d expected %0d", i, stall_cnt, scnt); end
      tick();
    end
    clear_inputs();
    while (md_rem > 0) tick();
  endtask

  task automatic test_saturation();
    clear_inputs();
    lw_hazard();
    repeat (SAT + 10) tick();
    n_checks++;
    if (int'(stall_cnt) !== SAT) begin n_fail++; $display("FAIL saturate: got %0d expected %0d", stall_cnt, SAT); end
    n_checks++;
    if (outs !== 7'b1110000) begin n_fail++; $display("FAIL sat_lock: got %b expected %b", outs, 7'b1110000); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_lw_use();
    test_zero_filter();
    test_div_busy();
    test_exception();
    test_eret();
    test_async_reset();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
